// File: rtl/qea_core.sv
// Quantum emulation accelerator: holds a 2^n complex state vector and applies a
// program of (optionally single-controlled) 2x2 unitary gates to it, one index pair at a time.
module qea_core #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_state_ena,
  input  logic                                 i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);
  localparam int SW = STATE_DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int WW = PE_NUM*SW;
  localparam int CW = GATE_CONTEXT_DATA_WIDTH;
  localparam int IW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int LW = GATE_CONTEXT_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_DONE} state_t;

  function automatic logic [DW-1:0] fmul(input logic [ALU_DATA_WIDTH-1:0] x, input logic [ALU_DATA_WIDTH-1:0] y);
    logic signed [2*ALU_DATA_WIDTH-1:0] p;
    p = $signed({{ALU_DATA_WIDTH{x[ALU_DATA_WIDTH-1]}}, x} * {{ALU_DATA_WIDTH{y[ALU_DATA_WIDTH-1]}}, y});
    p = p >>> NUM_FRAC_BIT;
    return p[DW-1:0];
  endfunction

  function automatic logic [SW-1:0] cmul(input logic [GATE_DATA_WIDTH-1:0] m, input logic [SW-1:0] s);
    logic [DW-1:0] re, im;
    re = fmul(m[2*DW-1:DW], s[2*DW-1:DW]) - fmul(m[DW-1:0], s[DW-1:0]);
    im = fmul(m[2*DW-1:DW], s[DW-1:0]) + fmul(m[DW-1:0], s[2*DW-1:DW]);
    return {re, im};
  endfunction

  function automatic logic [SW-1:0] cadd(input logic [SW-1:0] x, input logic [SW-1:0] y);
    return {x[2*DW-1:DW] + y[2*DW-1:DW], x[DW-1:0] + y[DW-1:0]};
  endfunction

  // Lane 0 sits in the most significant slot of a RAM word.
  function automatic logic [SW-1:0] get_lane(input logic [WW-1:0] w, input logic [PE_NUM_WIDTH-1:0] lane);
    int sh;
    sh = (PE_NUM - 1 - int'(lane)) * SW;
    return w[sh +: SW];
  endfunction

  function automatic logic [WW-1:0] set_lane(input logic [WW-1:0] w, input logic [PE_NUM_WIDTH-1:0] lane,
                                             input logic [SW-1:0] v);
    int sh;
    sh = (PE_NUM - 1 - int'(lane)) * SW;
    w[sh +: SW] = v;
    return w;
  endfunction

  state_t                       state_q, state_d;
  logic [GATE_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]                gptr_q, gptr_d, len_q;
  logic [IW-1:0]                k_q, k_d;
  logic [WW-1:0]                wi_q, wi_d, wj_q, wj_d, rd_q, dout_q;
  logic [SW-1:0]                nj_q, nj_d;
  logic                         complete_q, complete_d;
  logic [3:0]                   op_q;
  logic [MAX_QBIT_WIDTH-1:0]    t_q, c_q;
  logic [GATE_DATA_WIDTH-1:0]   ma_q, mb_q, mc_q, md_q;
  logic [CW-1:0]                ctx_rd_q;

  logic [WW-1:0] state_mem [0:(1<<STATE_ADDR_WIDTH)-1];
  logic [CW-1:0] ctx_mem   [0:(1<<GATE_CONTEXT_ADDR_WIDTH)-1];

  logic                               host_s, skip_s, ctrl_s, ctrl_bit_s, last_k_s, same_s;
  logic                               ram_we_s, eng_we_s, ctx_we_s;
  logic [IW-1:0]                      lo_mask_s, i_idx_s, j_idx_s;
  logic [IW:0]                        half_s;
  logic [STATE_ADDR_WIDTH-1:0]        eng_addr_s, ram_addr_s;
  logic [WW-1:0]                      eng_wdata_s, ram_wdata_s;
  logic [SW-1:0]                      si_s, sj_s, ni_s, nj_s;
  logic [LW-1:0]                      next_gptr_s;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_raddr_s;

  assign host_s     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign skip_s     = (op_q > 4'd1) || (t_q >= i_qbit_num) || (c_q >= i_qbit_num);
  assign ctrl_s     = (op_q == 4'd1) && (c_q != t_q);
  // Pair k maps to index i by inserting a zero at bit t; j is its partner with bit t set.
  assign lo_mask_s  = (IW'(1) << t_q) - IW'(1);
  assign i_idx_s    = ((k_q & ~lo_mask_s) << 1) | (k_q & lo_mask_s);
  assign j_idx_s    = i_idx_s | (IW'(1) << t_q);
  assign ctrl_bit_s = |((i_idx_s >> c_q) & IW'(1));
  assign half_s     = (IW+1)'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(1));
  assign last_k_s   = ({1'b0, k_q} == (half_s - (IW+1)'(1)));
  assign same_s     = (i_idx_s[IW-1:PE_NUM_WIDTH] == j_idx_s[IW-1:PE_NUM_WIDTH]);
  assign next_gptr_s = gptr_q + LW'(5);
  assign ctx_raddr_s = gptr_q[LW-2:0] + GATE_CONTEXT_ADDR_WIDTH'(cnt_q);
  assign ctx_we_s    = host_s && i_ctx_en && i_ctx_wea;

  assign si_s = get_lane(wi_q, i_idx_s[PE_NUM_WIDTH-1:0]);
  assign sj_s = get_lane(rd_q, j_idx_s[PE_NUM_WIDTH-1:0]);
  assign ni_s = cadd(cmul(ma_q, si_s), cmul(mb_q, sj_s));
  assign nj_s = cadd(cmul(mc_q, si_s), cmul(md_q, sj_s));

  assign eng_addr_s  = ((state_q == S_RD_J) || (state_q == S_WR_J)) ? j_idx_s[IW-1:PE_NUM_WIDTH]
                                                                     : i_idx_s[IW-1:PE_NUM_WIDTH];
  assign ram_addr_s  = host_s ? i_state_addra : eng_addr_s;
  assign ram_we_s    = host_s ? (i_state_ena && i_state_wea) : eng_we_s;
  assign ram_wdata_s = host_s ? i_state_dina : eng_wdata_s;

  assign o_complete   = complete_q;
  assign o_state_dout = dout_q;

  // Next-state and datapath control of the gate sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gptr_d      = gptr_q;
    k_d         = k_q;
    wi_d        = wi_q;
    wj_d        = wj_q;
    nj_d        = nj_q;
    complete_d  = complete_q;
    eng_we_s    = 1'b0;
    eng_wdata_s = {WW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CHECK;
          gptr_d  = {LW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (gptr_q >= len_q) begin
          state_d    = S_DONE;
          complete_d = 1'b1;
        end else begin
          state_d = S_FETCH;
          cnt_d   = {GATE_ADDR_WIDTH{1'b0}};
        end
      end
      S_FETCH: begin
        if (cnt_q == GATE_ADDR_WIDTH'(5)) begin
          if (skip_s) begin
            state_d = S_CHECK;
            gptr_d  = next_gptr_s;
          end else begin
            state_d = S_RD_I;
            k_d     = {IW{1'b0}};
          end
        end else begin
          cnt_d = cnt_q + GATE_ADDR_WIDTH'(1);
        end
      end
      S_RD_I: begin
        if (ctrl_s && !ctrl_bit_s) begin
          state_d = last_k_s ? S_CHECK : S_RD_I;
          gptr_d  = last_k_s ? next_gptr_s : gptr_q;
          k_d     = k_q + IW'(1);
        end else begin
          state_d = S_RD_J;
        end
      end
      S_RD_J: begin
        wi_d    = rd_q;
        state_d = S_WR_I;
      end
      S_WR_I: begin
        eng_we_s = 1'b1;
        wj_d     = rd_q;
        nj_d     = nj_s;
        if (same_s) begin
          eng_wdata_s = set_lane(set_lane(wi_q, i_idx_s[PE_NUM_WIDTH-1:0], ni_s), j_idx_s[PE_NUM_WIDTH-1:0], nj_s);
          state_d     = last_k_s ? S_CHECK : S_RD_I;
          gptr_d      = last_k_s ? next_gptr_s : gptr_q;
          k_d         = k_q + IW'(1);
        end else begin
          eng_wdata_s = set_lane(wi_q, i_idx_s[PE_NUM_WIDTH-1:0], ni_s);
          state_d     = S_WR_J;
        end
      end
      S_WR_J: begin
        eng_we_s    = 1'b1;
        eng_wdata_s = set_lane(wj_q, j_idx_s[PE_NUM_WIDTH-1:0], nj_q);
        state_d     = last_k_s ? S_CHECK : S_RD_I;
        gptr_d      = last_k_s ? next_gptr_s : gptr_q;
        k_d         = k_q + IW'(1);
      end
      S_DONE: begin
        if (i_start) begin
          state_d    = S_CHECK;
          complete_d = 1'b0;
          gptr_d     = {LW{1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers, gate fetch buffer and host read port.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= {GATE_ADDR_WIDTH{1'b0}};
      gptr_q     <= {LW{1'b0}};
      len_q      <= {LW{1'b0}};
      k_q        <= {IW{1'b0}};
      wi_q       <= {WW{1'b0}};
      wj_q       <= {WW{1'b0}};
      nj_q       <= {SW{1'b0}};
      complete_q <= 1'b0;
      dout_q     <= {WW{1'b0}};
      op_q       <= 4'd0;
      t_q        <= {MAX_QBIT_WIDTH{1'b0}};
      c_q        <= {MAX_QBIT_WIDTH{1'b0}};
      ma_q       <= {GATE_DATA_WIDTH{1'b0}};
      mb_q       <= {GATE_DATA_WIDTH{1'b0}};
      mc_q       <= {GATE_DATA_WIDTH{1'b0}};
      md_q       <= {GATE_DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gptr_q     <= gptr_d;
      k_q        <= k_d;
      wi_q       <= wi_d;
      wj_q       <= wj_d;
      nj_q       <= nj_d;
      complete_q <= complete_d;
      if (ctx_we_s) len_q <= {1'b0, i_ctx_addr} + LW'(1);
      if (host_s && i_state_ena) dout_q <= state_mem[ram_addr_s];
      if (state_q == S_FETCH) begin
        case (cnt_q)
          GATE_ADDR_WIDTH'(1): begin
            op_q <= ctx_rd_q[CW-1 -: 4];
            t_q  <= ctx_rd_q[CW-7 -: MAX_QBIT_WIDTH];
            c_q  <= ctx_rd_q[CW-13 -: MAX_QBIT_WIDTH];
          end
          GATE_ADDR_WIDTH'(2): ma_q <= ctx_rd_q;
          GATE_ADDR_WIDTH'(3): mb_q <= ctx_rd_q;
          GATE_ADDR_WIDTH'(4): mc_q <= ctx_rd_q;
          GATE_ADDR_WIDTH'(5): md_q <= ctx_rd_q;
          default: ;
        endcase
      end
    end
  end

  // State and program RAMs, read-first.
  always_ff @(posedge clk) begin
    rd_q     <= state_mem[ram_addr_s];
    ctx_rd_q <= ctx_mem[ctx_raddr_s];
    if (ram_we_s) state_mem[ram_addr_s] <= ram_wdata_s;
    if (ctx_we_s) ctx_mem[i_ctx_addr] <= i_ctx_data;
  end
endmodule

// File: tb/tb_qea_core.sv
// Randomized and directed checks of qea_core against an index-pair reference model.
module tb_qea_core;
  localparam logic [63:0] ONE = 64'h40000000_00000000;
  localparam logic [63:0] HQ  = 64'h2D413CCC_00000000;
  localparam logic [63:0] HN  = 64'hD2BEC334_00000000;
  localparam logic [63:0] ZER = 64'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [5:0] qbit_num = 6'd2;
  logic ctx_en = 1'b0, ctx_wea = 1'b0;
  logic [15:0] ctx_addr = 16'h0;
  logic [63:0] ctx_data = 64'h0;
  logic st_en = 1'b0, st_wea = 1'b0;
  logic [15:0] st_addr = 16'h0;
  logic [255:0] st_din = 256'h0;
  logic complete;
  logic [255:0] dout;

  always #5 clk = ~clk;

  qea_core dut (
    .clk(clk), .rst_n(rst), .i_start(start), .i_qbit_num(qbit_num),
    .i_ctx_en(ctx_en), .i_ctx_wea(ctx_wea), .i_ctx_addr(ctx_addr), .i_ctx_data(ctx_data),
    .i_state_ena(st_en), .i_state_wea(st_wea), .i_state_addra(st_addr), .i_state_dina(st_din),
    .o_complete(complete), .o_state_dout(dout)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] mdl  [0:63];
  logic [63:0] prog [0:39];
  int n_gates = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fx(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p >>> 30;
    return p[31:0];
  endfunction

  function automatic logic [63:0] cm(input logic [63:0] m, input logic [63:0] s);
    logic [31:0] re, im;
    re = fx(m[63:32], s[63:32]) - fx(m[31:0], s[31:0]);
    im = fx(m[63:32], s[31:0]) + fx(m[31:0], s[63:32]);
    return {re, im};
  endfunction

  function automatic logic [63:0] ca(input logic [63:0] x, input logic [63:0] y);
    return {x[63:32] + y[63:32], x[31:0] + y[31:0]};
  endfunction

  function automatic logic [255:0] pack(input int a);
    return {mdl[4*a], mdl[4*a+1], mdl[4*a+2], mdl[4*a+3]};
  endfunction

  task automatic add_gate(input int op, input int t, input int c,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] cc, input logic [63:0] d);
    logic [63:0] h;
    h = 64'h0;
    h[63:60] = op[3:0];
    h[57:52] = t[5:0];
    h[51:46] = c[5:0];
    prog[5*n_gates]   = h;
    prog[5*n_gates+1] = a;
    prog[5*n_gates+2] = b;
    prog[5*n_gates+3] = cc;
    prog[5*n_gates+4] = d;
    n_gates++;
  endtask

  // Each gate reads only the snapshot taken before it.
  task automatic model_run(input int n);
    logic [63:0] pre [0:63];
    logic [63:0] h;
    int op, t, c, j;
    for (int g = 0; g < n_gates; g++) begin
      h  = prog[5*g];
      op = int'(h[63:60]);
      t  = int'(h[57:52]);
      c  = int'(h[51:46]);
      if (op > 1 || t >= n || c >= n) continue;
      pre = mdl;
      for (int i = 0; i < (1 << n); i++) begin
        if (((i >> t) & 1) != 0) continue;
        if (op == 1 && c != t && ((i >> c) & 1) == 0) continue;
        j = i | (1 << t);
        mdl[i] = ca(cm(prog[5*g+1], pre[i]), cm(prog[5*g+2], pre[j]));
        mdl[j] = ca(cm(prog[5*g+3], pre[i]), cm(prog[5*g+4], pre[j]));
      end
    end
  endtask

  task automatic load_prog();
    @(negedge clk);
    for (int w = 0; w < 5*n_gates; w++) begin
      ctx_en = 1'b1; ctx_wea = 1'b1; ctx_addr = 16'(w); ctx_data = prog[w];
      @(negedge clk);
    end
    ctx_en = 1'b0; ctx_wea = 1'b0;
  endtask

  task automatic load_state(input int n);
    @(negedge clk);
    for (int a = 0; a < (1 << n) / 4; a++) begin
      st_en = 1'b1; st_wea = 1'b1; st_addr = 16'(a); st_din = pack(a);
      @(negedge clk);
    end
    st_en = 1'b0; st_wea = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [255:0] d);
    @(negedge clk);
    st_en = 1'b1; st_wea = 1'b0; st_addr = 16'(a);
    @(negedge clk);
    st_en = 1'b0;
    d = dout;
  endtask

  task automatic check_state(input int n, input string tag);
    logic [255:0] d;
    for (int a = 0; a < (1 << n) / 4; a++) begin
      read_word(a, d);
      check($sformatf("%s_w%0d", tag, a), d, pack(a));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int cyc, budget;
    cyc = 0;
    budget = 8 * (1 << n) * n_gates + 16;
    while (complete !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, {255'h0, complete}, 256'h1);
  endtask

  task automatic run_case(input int n, input string tag);
    qbit_num = 6'(n);
    load_prog();
    load_state(n);
    model_run(n);
    pulse_start();
    check({tag, "_clr"}, {255'h0, complete}, 256'h0);
    wait_done(n, tag);
    check_state(n, tag);
  endtask

  task automatic clear_basis(input int n);
    for (int i = 0; i < 64; i++) mdl[i] = (i == 0) ? ONE : ZER;
    n_gates = 0;
    qbit_num = 6'(n);
  endtask

  task automatic random_prog(input int n, input int g);
    int r, op;
    n_gates = 0;
    for (int i = 0; i < 64; i++) mdl[i] = {$urandom, $urandom};
    for (int k = 0; k < g; k++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 0 : (r < 8) ? 1 : $urandom_range(2, 15);
      add_gate(op, $urandom_range(0, n), $urandom_range(0, n),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
  endtask

  initial begin
    logic [255:0] d;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_complete", {255'h0, complete}, 256'h0);
    check("rst_dout", dout, 256'h0);
    rst = 1'b0;

    // empty program after reset finishes quickly and leaves the state alone
    for (int i = 0; i < 64; i++) mdl[i] = {$urandom, $urandom};
    n_gates = 0;
    qbit_num = 6'd2;
    load_state(2);
    pulse_start();
    wait_done(2, "empty");
    check_state(2, "empty");

    clear_basis(4);
    add_gate(0, 0, 0, ONE, ZER, ZER, ONE);
    run_case(4, "ident");
    read_word(0, d);
    check("ident_const", d, {ONE, 192'h0});

    clear_basis(4);
    add_gate(0, 0, 0, ZER, ONE, ONE, ZER);
    run_case(4, "x_t0");
    read_word(0, d);
    check("x_const", d, {ZER, ONE, 128'h0});

    // write zeros while reading: old word comes back, new word lands
    @(negedge clk);
    st_en = 1'b1; st_wea = 1'b1; st_addr = 16'h0; st_din = 256'h0;
    @(negedge clk);
    st_en = 1'b0; st_wea = 1'b0;
    check("rmw_old", dout, {ZER, ONE, 128'h0});
    read_word(0, d);
    check("rmw_new", d, 256'h0);

    clear_basis(4);
    add_gate(0, 2, 0, HQ, HQ, HQ, HN);
    run_case(4, "h_t2");
    read_word(0, d);
    check("h_w0", d, {HQ, 192'h0});
    read_word(1, d);
    check("h_w1", d, {HQ, 192'h0});

    clear_basis(4);
    add_gate(0, 0, 0, HQ, HQ, HQ, HN);
    add_gate(1, 1, 0, ZER, ONE, ONE, ZER);
    run_case(4, "bell");
    read_word(0, d);
    check("bell_w0", d, {HQ, 128'h0, HQ});

    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(2, 6);
      random_prog(n, $urandom_range(1, 6));
      run_case(n, $sformatf("rnd%0d", it));
    end

    // start and host accesses during BUSY must be ignored
    random_prog(6, 4);
    qbit_num = 6'd6;
    load_prog();
    load_state(6);
    model_run(6);
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1; st_en = 1'b1; st_wea = 1'b1; st_addr = 16'h0; st_din = {8{32'hDEADBEEF}};
    ctx_en = 1'b1; ctx_wea = 1'b1; ctx_addr = 16'd39; ctx_data = 64'h0;
    @(negedge clk);
    start = 1'b0; st_en = 1'b0; st_wea = 1'b0; ctx_en = 1'b0; ctx_wea = 1'b0;
    wait_done(6, "busy");
    check_state(6, "busy");

    // reset in the middle of a run, then a fresh run from reloaded contents
    random_prog(6, 4);
    qbit_num = 6'd6;
    load_prog();
    load_state(6);
    pulse_start();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_complete", {255'h0, complete}, 256'h0);
    check("midrst_dout", dout, 256'h0);
    rst = 1'b0;
    run_case(6, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/qea_core.md
Name: qea_core

Overview:
- Quantum emulation accelerator. It holds a complex state vector of 2^n amplitudes and a gate program, then applies the program's 2x2 unitary gates (plain or single-controlled) to the state.
- Used as a slave compute block. The host loads the program and the state through RAM-style ports, pulses start, waits for the complete flag, then reads the state back.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, amplitudes per state-RAM word (lanes).
- DATA_WIDTH, 32, width of one real or imaginary component, signed fixed point.
- MAX_QBIT_WIDTH, 6, width of qubit count and qubit index fields.
- ALU_DATA_WIDTH, DATA_WIDTH, multiplier operand width.
- STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude: real in the upper half, imaginary in the lower half.
- STATE_ADDR_WIDTH, 16, state RAM address width.
- GATE_DATA_WIDTH, 2*DATA_WIDTH, complex matrix element width.
- GATE_ADDR_WIDTH, 6, reserved; must still be accepted as a parameter.
- GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, program word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, program RAM address width.
- NUM_FRAC_BIT, 30, fractional bits (Q2.30; 1.0 = 0x40000000).

Ports:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous reset, active-high (asserted = 1, despite the name).
- i_start, in, 1, single-cycle start pulse.
- i_qbit_num, in, MAX_QBIT_WIDTH, qubit count n; n ≥ PE_NUM_WIDTH.
- i_ctx_en, in, 1, program RAM enable.
- i_ctx_wea, in, 1, program RAM write enable.
- i_ctx_addr, in, GATE_CONTEXT_ADDR_WIDTH, program RAM address.
- i_ctx_data, in, GATE_CONTEXT_DATA_WIDTH, program write data.
- i_state_ena, in, 1, state RAM enable.
- i_state_wea, in, 1, state RAM write enable.
- i_state_addra, in, STATE_ADDR_WIDTH, state RAM word address.
- i_state_dina, in, PE_NUM*STATE_DATA_WIDTH, state write word.
- o_complete, out, 1, program finished.
- o_state_dout, out, PE_NUM*STATE_DATA_WIDTH, state read word.

Behaviour:
- Reset: o_complete=0; o_state_dout=0; FSM to IDLE; program length=0. RAM contents are not cleared.
- Amplitude index k = addr*PE_NUM + lane.
- Lane p occupies bits [(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH]; lane 0 is in the MSBs.
- Program RAM writes are synchronous: en&wea writes data at addr.
- Program length register = (last written address)+1; it is updated on every write.
- Program format: groups of 5 words. Word 0 is the header, words 1-4 are matrix elements a, b, c, d.
- Header fields: [63:60] opcode (0 = U, 1 = controlled U; other values are treated as NOP but the group is still consumed), [57:52] target qubit t, [51:46] control qubit c.
- Gate semantics: for every index pair i (bit t = 0), j = i | (1<<t):
  - s_i' = a*s_i + b*s_j
  - s_j' = c*s_i + d*s_j
  - For opcode 1, only pairs with bit c of i set are updated.
- Complex multiply: full 2*DATA_WIDTH-bit signed products, arithmetic right shift by NUM_FRAC_BIT, then truncate to DATA_WIDTH. Sums wrap modulo 2^DATA_WIDTH; no saturation.
- All updates within one gate use that gate's pre-gate state. Gates execute in program order.
- State port: synchronous, read-first. When en=1, o_state_dout <= old word at addr on the next edge (1-cycle latency); when wea=1 the word is also written.
- When en=0, o_state_dout holds its value.
- Host state and program accesses are honoured only in IDLE/DONE; they are ignored while BUSY.
- FSM:
  - IDLE -> BUSY on i_start.
  - BUSY runs gates until the group pointer reaches the program length, then goes to DONE.
  - DONE holds o_complete=1 until the next i_start, which clears o_complete the following cycle and re-enters BUSY.
- i_start while BUSY is ignored.
- Program length 0: BUSY -> DONE in 1 cycle.
- t or c ≥ n: gate is skipped. c == t: treated as opcode 0.
- Reset mid-run: aborts immediately to IDLE; state RAM contents are undefined.
- Throughput is free. Latency from start to complete must be ≤ 8*(2^n)*gates + 16 cycles.

Test Plan:
- Load header 0x0 (U, t=0) and matrix a=d=0x40000000_00000000, b=c=0; state index0 = 0x40000000_00000000, n=4; start -> o_complete rises; readback addr0 lane0 = 0x40000000_00000000, all else 0.
- X on t=0 (a=d=0, b=c=1.0) from |0000> -> index1 (addr0, bits[191:128]) = 0x40000000_00000000, index0 = 0.
- H on t=2 (a=b=c=0x2D413CCC, d=0xD2BEC334 real) from |0000> -> indices 0 and 4 real = 0x2D413CCC, all other amplitudes 0.
- H(t=0) then CU (c=0, t=1, X matrix) -> indices 0 and 3 = 0x2D413CCC, others 0.
- Readback with wea=1, dina=0 -> o_state_dout shows pre-write data 1 cycle after address.
- i_start pulsed again while BUSY -> ignored; rst_n=1 mid-run -> o_complete=0 and FSM in IDLE; a fresh start then runs to completion.
